// File: rtl/axis_checker_pkg.sv
// Shared types and constants for the AXI-Stream checker.
// Holds the FSM encoding, LFSR seed/taps and the all-ones strobe helper.
package axis_checker_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Fibonacci LFSR, taps 8,6,5,4 -> bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Widest strobe the helper supports (DATA_WIDTH up to 1024)
    localparam int STRB_MAX = 128;

    // All-ones strobe for a DATA_WIDTH-bit bus, LSB-aligned in a STRB_MAX vector
    function automatic logic [STRB_MAX-1:0] strb_all_ones(input int data_width);
        logic [STRB_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < STRB_MAX; i++) begin
            if (i < data_width / 8) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_stream_checker_lfsr8.sv
// 8-bit Fibonacci LFSR used to generate pseudo-random backpressure stalls.
// Advances every clock; reloads the seed on reset.
module lfsr8
    import axis_checker_pkg::*;
(
    input  logic       clk,
    input  logic       areset,
    output logic [7:0] q
);

    logic [7:0] r_q;

    // Shift left, XOR of tapped bits enters at bit 0
    always_ff @(posedge clk or posedge areset) begin
        if (areset) r_q <= LFSR_SEED;
        else        r_q <= {r_q[6:0], ^(r_q & LFSR_TAPS)};
    end

    assign q = r_q;

endmodule

// File: rtl/axis_stream_checker.sv
// AXI-Stream sink that checks an incrementing-counter stream: data pattern,
// all-ones tstrb and fixed packet length, with saturating counters and
// sticky error flags.
// Optional: define AXIS_CHECKER_BACKPRESSURE_EN to gate tready with an LFSR.
module axis_stream_checker
    import axis_checker_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    s00_axis_aclk,
    input  logic                    s00_axis_areset,
    input  logic                    enable,
    input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                    s00_axis_tvalid,
    output logic                    s00_axis_tready,
    input  logic                    s00_axis_tlast,
    output logic [CNT_WIDTH-1:0]    pkt_count,
    output logic [CNT_WIDTH-1:0]    err_count,
    output logic                    data_err,
    output logic                    strb_err,
    output logic                    len_err,
    output logic                    busy
);

    localparam int                  STRB_W   = DATA_WIDTH / 8;
    localparam logic [STRB_MAX-1:0] STRB_ALL = strb_all_ones(DATA_WIDTH);
    localparam logic [15:0]         LAST_IDX = 16'(PKT_LEN - 1);

    state_t                  r_state, w_next;
    logic                    r_tready;
    logic [DATA_WIDTH-1:0]   r_exp;
    logic [15:0]             r_idx;
    logic [CNT_WIDTH-1:0]    r_pkt, r_err;
    logic                    r_data_err, r_strb_err, r_len_err;

    logic w_tready, w_accept, w_last_idx;
    logic w_data_bad, w_strb_bad, w_len_bad, w_pkt_end;

`ifdef AXIS_CHECKER_BACKPRESSURE_EN
    logic [7:0] w_lfsr;

    lfsr8 u_lfsr (
        .clk    (s00_axis_aclk),
        .areset (s00_axis_areset),
        .q      (w_lfsr)
    );

    // Both operands are flops, so tready stays independent of tvalid
    assign w_tready = r_tready & w_lfsr[0];
`else
    assign w_tready = r_tready;
`endif

    assign w_accept   = s00_axis_tvalid & w_tready;
    assign w_last_idx = (r_idx == LAST_IDX);
    assign w_data_bad = (s00_axis_tdata != r_exp);
    assign w_strb_bad = (s00_axis_tstrb != STRB_ALL[STRB_W-1:0]);
    // tlast must coincide exactly with the final index
    assign w_len_bad  = s00_axis_tlast ^ w_last_idx;
    // Packet boundary: real tlast, or a missing tlast at the final index
    assign w_pkt_end  = w_accept & (s00_axis_tlast | w_last_idx);

    // State register
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) r_state <= S_IDLE;
        else                 r_state <= w_next;
    end

    // Next state: disable only takes effect on a packet boundary
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (enable) w_next = S_RECV;
            S_RECV:  if (w_pkt_end && !enable) w_next = S_DRAIN;
            S_DRAIN: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // tready registered from the next state so it rises with S_RECV
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) r_tready <= 1'b0;
        else                 r_tready <= (w_next == S_RECV);
    end

    // Per-beat checks, expected value tracking and counters
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            r_exp      <= '0;
            r_idx      <= '0;
            r_pkt      <= '0;
            r_err      <= '0;
            r_data_err <= 1'b0;
            r_strb_err <= 1'b0;
            r_len_err  <= 1'b0;
        end else if (w_accept) begin
            // Match: tdata+1 == exp+1. Mismatch: resync to the received value.
            r_exp <= s00_axis_tdata + 1'b1;
            r_idx <= w_pkt_end ? 16'd0 : r_idx + 16'd1;
            if (w_data_bad) r_data_err <= 1'b1;
            if (w_strb_bad) r_strb_err <= 1'b1;
            if (w_len_bad)  r_len_err  <= 1'b1;
            if ((w_data_bad | w_strb_bad | w_len_bad) && (r_err != '1))
                r_err <= r_err + 1'b1;
            if (s00_axis_tlast && (r_pkt != '1))
                r_pkt <= r_pkt + 1'b1;
        end
    end

    assign s00_axis_tready = w_tready;
    assign busy            = (r_state == S_RECV);
    assign pkt_count       = r_pkt;
    assign err_count       = r_err;
    assign data_err        = r_data_err;
    assign strb_err        = r_strb_err;
    assign len_err         = r_len_err;

endmodule

// File: tb/tb_axis_stream_checker.sv
// Directed bench for axis_stream_checker: table of single-packet error
// scenarios plus hand-written sequences for timing, drain, async reset,
// saturation and random tvalid gaps.
module tb_axis_stream_checker;

    localparam int DW = 32;
    localparam int PL = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [DW-1:0] tdata = '0;
    logic [3:0]    tstrb = '0;
    logic          tvalid = 1'b0;
    logic          tlast = 1'b0;
    logic          tready;
    logic [CW-1:0] pkt_count, err_count;
    logic          data_err, strb_err, len_err, busy;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] nextd = '0;
    logic          mon_en = 1'b0;
    int            n_stall = 0;

    always #5 clk = ~clk;

    axis_stream_checker #(.DATA_WIDTH(DW), .PKT_LEN(PL), .CNT_WIDTH(CW)) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .enable          (enable),
        .s00_axis_tdata  (tdata),
        .s00_axis_tstrb  (tstrb),
        .s00_axis_tvalid (tvalid),
        .s00_axis_tready (tready),
        .s00_axis_tlast  (tlast),
        .pkt_count       (pkt_count),
        .err_count       (err_count),
        .data_err        (data_err),
        .strb_err        (strb_err),
        .len_err         (len_err),
        .busy            (busy)
    );

    // Count cycles inside S_RECV where the sink refused data
    always @(negedge clk) if (mon_en && busy && !tready) n_stall++;

    typedef struct {
        int          bad_beat;
        logic [31:0] bad_data;
        int          strb_beat;
        logic [3:0]  strb_val;
        int          last_at;   // index carrying tlast; PL means no tlast at all
        logic        e_data, e_strb, e_len;
        int          e_err, e_pkt;
    } vec_t;

    vec_t vt[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; enable = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        nextd = '0;
    endtask

    task automatic start();
        enable = 1'b1;
        tick();
    endtask

    // Present one beat and hold it until accepted (bounded wait)
    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n = 0;
        tvalid = 1'b1; tdata = d; tstrb = s; tlast = l;
        while (!tready && n < 64) begin
            tick();
            n++;
        end
        if (!tready) check("tready_timeout", 64'd0, 64'd1);
        tick();
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic send_pkt(input int bad_beat, input logic [31:0] bad_data,
                            input int strb_beat, input logic [3:0] strb_val,
                            input int last_at, input bit gap);
        int nb = (last_at < PL) ? last_at + 1 : PL;
        logic [31:0] d;
        for (int i = 0; i < nb; i++) begin
            d = (i == bad_beat) ? bad_data : nextd;
            nextd = d + 1;
            if (gap && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
            send_beat(d, (i == strb_beat) ? strb_val : 4'hF, i == last_at);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int npk;
        //          bad  data          sbeat sval  last  D  S  L  err pkt
        vt[0] = '{-1, 32'h0,        -1, 4'hF, 15, 0, 0, 0, 0, 2};
        vt[1] = '{ 5, 32'hDEAD,     -1, 4'hF, 15, 1, 0, 0, 1, 2};
        vt[2] = '{-1, 32'h0,         3, 4'h7, 15, 0, 1, 0, 1, 2};
        vt[3] = '{-1, 32'h0,        -1, 4'hF, 10, 0, 0, 1, 1, 2};
        vt[4] = '{-1, 32'h0,        -1, 4'hF, PL, 0, 0, 1, 1, 1};
        vt[5] = '{ 7, 32'hDEAD,      7, 4'h7, 15, 1, 1, 0, 1, 2};
        vt[6] = '{-1, 32'h0,        -1, 4'hF,  0, 0, 0, 1, 1, 2};
        vt[7] = '{15, 32'h0,        -1, 4'hF, 15, 1, 0, 0, 1, 2};

        // Reset state
        do_reset();
        check("rst_tready", tready, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt", pkt_count, 0);
        check("rst_err", err_count, 0);
        check("rst_flags", {data_err, strb_err, len_err}, 0);

        // tready rises one edge after enable is seen
        enable = 1'b1;
        check("en_tready_lo", tready, 0);
        tick();
        check("en_busy", busy, 1);
`ifndef AXIS_CHECKER_BACKPRESSURE_EN
        check("en_tready_hi", tready, 1);
`endif

        // Three clean packets, data 0..47
        for (int p = 0; p < 3; p++) send_pkt(-1, 0, -1, 4'hF, 15, 0);
        check("clean3_pkt", pkt_count, 3);
        check("clean3_err", err_count, 0);
        check("clean3_flags", {data_err, strb_err, len_err}, 0);

        // Table: one modified packet followed by a clean one
        for (int k = 0; k < 8; k++) begin
            do_reset();
            start();
            send_pkt(vt[k].bad_beat, vt[k].bad_data, vt[k].strb_beat, vt[k].strb_val, vt[k].last_at, 0);
            send_pkt(-1, 0, -1, 4'hF, 15, 0);
            check($sformatf("vec%0d_data_err", k), data_err, vt[k].e_data);
            check($sformatf("vec%0d_strb_err", k), strb_err, vt[k].e_strb);
            check($sformatf("vec%0d_len_err", k), len_err, vt[k].e_len);
            check($sformatf("vec%0d_err_count", k), err_count, vt[k].e_err);
            check($sformatf("vec%0d_pkt_count", k), pkt_count, vt[k].e_pkt);
        end

        // enable dropped mid-packet: packet completes, then one drain cycle
        do_reset();
        start();
        for (int i = 0; i < PL; i++) begin
            if (i == 8) enable = 1'b0;
            send_beat(nextd, 4'hF, i == PL - 1);
            nextd = nextd + 1;
        end
        check("drop_pkt", pkt_count, 1);
        check("drop_err", err_count, 0);
        check("drop_tready_drain", tready, 0);
        check("drop_busy_drain", busy, 0);
        tick();
        check("drop_tready_idle", tready, 0);
        check("drop_busy_idle", busy, 0);

        // Next packet aborted by async reset at beat 3
        start();
        send_beat(nextd, 4'hF, 0); nextd = nextd + 1;
        send_beat(nextd, 4'h0, 0); nextd = nextd + 1;
        send_beat(nextd, 4'hF, 0); nextd = nextd + 1;
        check("abort_pre_strb", strb_err, 1);
        tvalid = 1'b1; tdata = nextd; tstrb = 4'hF;
        #2 rst = 1'b1;
        #1;
        check("abort_pkt", pkt_count, 0);
        check("abort_err", err_count, 0);
        check("abort_flags", {data_err, strb_err, len_err}, 0);
        check("abort_tready", tready, 0);
        check("abort_busy", busy, 0);
        tick();
        tvalid = 1'b0; enable = 1'b0; rst = 1'b0; nextd = '0;
        tick();
        start();
        send_pkt(-1, 0, -1, 4'hF, 15, 0);
        check("post_abort_pkt", pkt_count, 1);
        check("post_abort_err", err_count, 0);
        check("post_abort_flags", {data_err, strb_err, len_err}, 0);

        // Saturation: every beat has a bad strobe, 260 packets
        do_reset();
        start();
        for (int p = 0; p < 260; p++) begin
            for (int i = 0; i < PL; i++) begin
                send_beat(nextd, 4'h0, i == PL - 1);
                nextd = nextd + 1;
            end
        end
        check("sat_pkt", pkt_count, 8'hFF);
        check("sat_err", err_count, 8'hFF);
        check("sat_flags", {data_err, strb_err, len_err}, 3'b010);

        // Random tvalid gaps (and LFSR stalls when backpressure is built in)
`ifdef AXIS_CHECKER_BACKPRESSURE_EN
        npk = 100;
`else
        npk = 20;
`endif
        do_reset();
        start();
        mon_en = 1'b1;
        for (int p = 0; p < npk; p++) send_pkt(-1, 0, -1, 4'hF, 15, 1);
        mon_en = 1'b0;
        check("gap_pkt", pkt_count, npk);
        check("gap_err", err_count, 0);
        check("gap_flags", {data_err, strb_err, len_err}, 0);
`ifdef AXIS_CHECKER_BACKPRESSURE_EN
        check("gap_stalls_seen", n_stall > 0, 1);
`else
        check("gap_no_stalls", n_stall, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
